// File: rtl/ex_muldiv_unit_if.sv
// Bundle between the EX stage and the multiply/divide unit: instruction and
// operands in; Start/Busy, HI/LO and the mfhi/mflo read value out.
interface ex_muldiv_unit_if;
  logic [31:0] IR_E;
  logic [31:0] RS_E;
  logic [31:0] RT_E;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MD_Out;

  modport master (output IR_E, RS_E, RT_E, input Start, Busy, HI, LO, MD_Out);
  modport slave  (input IR_E, RS_E, RT_E, output Start, Busy, HI, LO, MD_Out);
endinterface

// File: rtl/ex_muldiv_unit.sv
// EX-stage multi-cycle multiply/divide unit with private HI/LO registers.
// Optional MD_MADD_EN adds madd/maddu (accumulate into {HI,LO}).
//
// state  | meaning
// S_IDLE | no operation in flight; accepts starts and mthi/mtlo
// S_BUSY | result captured, counting down to the HI/LO commit
module ex_muldiv_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic          Clk,
  input logic          Reset,
  ex_muldiv_unit_if.slave md
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic          commit_q, commit_d;

  logic [5:0] op, fn;
  logic       is_r, is_mult, is_multu, is_div, is_divu;
  logic       is_mfhi, is_mthi, is_mflo, is_mtlo, is_madd, is_maddu;
  logic       is_mul_op, is_div_op;
  logic       unused_ir;

  assign op        = md.IR_E[31:26];
  assign fn        = md.IR_E[5:0];
  assign unused_ir = ^md.IR_E[25:6];
  assign is_r      = (op == 6'b000000);
  assign is_mult   = is_r && (fn == 6'b011000);
  assign is_multu  = is_r && (fn == 6'b011001);
  assign is_div    = is_r && (fn == 6'b011010);
  assign is_divu   = is_r && (fn == 6'b011011);
  assign is_mfhi   = is_r && (fn == 6'b010000);
  assign is_mthi   = is_r && (fn == 6'b010001);
  assign is_mflo   = is_r && (fn == 6'b010010);
  assign is_mtlo   = is_r && (fn == 6'b010011);
`ifdef MD_MADD_EN
  assign is_madd   = (op == 6'b011100) && (fn == 6'b000000);
  assign is_maddu  = (op == 6'b011100) && (fn == 6'b000001);
`else
  assign is_madd   = 1'b0;
  assign is_maddu  = 1'b0;
`endif
  assign is_mul_op = is_mult | is_multu | is_madd | is_maddu;
  assign is_div_op = is_div | is_divu;

  // Products are formed at full 64-bit width so no extension is implicit.
  logic [63:0] rs_sx, rt_sx, rs_zx, rt_zx, prod_s, prod_u, mul_res;
  assign rs_sx  = {{32{md.RS_E[31]}}, md.RS_E};
  assign rt_sx  = {{32{md.RT_E[31]}}, md.RT_E};
  assign rs_zx  = {32'd0, md.RS_E};
  assign rt_zx  = {32'd0, md.RT_E};
  assign prod_s = rs_sx * rt_sx;
  assign prod_u = rs_zx * rt_zx;

  always_comb begin
    mul_res = prod_s;
    if (is_multu)     mul_res = prod_u;
    else if (is_madd) mul_res = {hi_q, lo_q} + prod_s;
    else if (is_maddu) mul_res = {hi_q, lo_q} + prod_u;
  end

  // Divisor 0 is steered to 1 so the datapath never produces X; that result is dropped.
  logic [31:0]        div_b, q_u, r_u;
  logic signed [31:0] q_s, r_s;
  always_comb begin
    div_b = (md.RT_E == 32'd0) ? 32'd1 : md.RT_E;
    q_s   = $signed(md.RS_E) / $signed(div_b);
    r_s   = $signed(md.RS_E) % $signed(div_b);
    if (md.RS_E == 32'h8000_0000 && md.RT_E == 32'hFFFF_FFFF) begin
      q_s = 32'sh8000_0000;
      r_s = 32'sd0;
    end
    q_u = md.RS_E / div_b;
    r_u = md.RS_E % div_b;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    commit_d = commit_q;
    case (state_q)
      S_IDLE: begin
        if (is_mul_op) begin
          state_d  = S_BUSY;
          cnt_d    = CW'(MULT_CYCLES);
          res_hi_d = mul_res[63:32];
          res_lo_d = mul_res[31:0];
          commit_d = 1'b1;
        end else if (is_div_op) begin
          state_d  = S_BUSY;
          cnt_d    = CW'(DIV_CYCLES);
          res_hi_d = is_div ? r_s : r_u;
          res_lo_d = is_div ? q_s : q_u;
          commit_d = (md.RT_E != 32'd0);
        end else if (is_mthi) begin
          hi_d = md.RS_E;
        end else if (is_mtlo) begin
          lo_d = md.RS_E;
        end
      end
      S_BUSY: begin
        if (cnt_q <= CW'(1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          if (commit_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      commit_q <= commit_d;
    end
  end

  assign md.Busy   = (state_q == S_BUSY);
  assign md.Start  = (is_mul_op | is_div_op) && (state_q == S_IDLE);
  assign md.HI     = hi_q;
  assign md.LO     = lo_q;
  assign md.MD_Out = is_mfhi ? hi_q : (is_mflo ? lo_q : 32'd0);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: stimulus pushes expected HI/LO and Busy
// length, a negedge monitor pops and checks when Busy falls.
module tb_ex_muldiv_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_muldiv_unit_if mdif();

  ex_muldiv_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk  (clk),
    .Reset(rst),
    .md   (mdif)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  localparam logic [31:0] MULT  = 32'h0000_0018;
  localparam logic [31:0] MULTU = 32'h0000_0019;
  localparam logic [31:0] DIV   = 32'h0000_001A;
  localparam logic [31:0] DIVU  = 32'h0000_001B;
  localparam logic [31:0] MFHI  = 32'h0000_0010;
  localparam logic [31:0] MTHI  = 32'h0000_0011;
  localparam logic [31:0] MFLO  = 32'h0000_0012;
  localparam logic [31:0] MTLO  = 32'h0000_0013;
  localparam logic [31:0] MADD  = 32'h7000_0000;
  localparam logic [31:0] MADDU = 32'h7000_0001;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic expect_op(input logic [31:0] hi, input logic [31:0] lo, input int cyc, input string nm);
    exp_t e;
    e.hi = hi; e.lo = lo; e.cyc = cyc; e.nm = nm;
    sb.push_back(e);
  endtask

  // Called at posedge+1: drive, check Start before the edge, then bubble with junk operands.
  task automatic issue(input logic [31:0] ir, input logic [31:0] rs, input logic [31:0] rt,
                       input logic exp_start, input string nm);
    mdif.IR_E = ir; mdif.RS_E = rs; mdif.RT_E = rt;
    #1;
    chk({nm, " Start"}, {31'd0, mdif.Start}, {31'd0, exp_start});
    @(posedge clk); #1;
    mdif.IR_E = 32'd0; mdif.RS_E = $urandom; mdif.RT_E = $urandom;
  endtask

  task automatic wait_done(input string nm);
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(posedge clk); t++;
    end
    #1;
    chk({nm, " drain"}, sb.size(), 32'd0);
  endtask

  // Monitor
  initial begin
    int   bcnt = 0;
    logic busy_prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        bcnt = 0; busy_prev = 1'b0;
      end else begin
        if (mdif.Busy) bcnt++;
        else if (busy_prev) begin
          if (sb.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL sb_empty: Busy fell with no expected result at %0t", $time);
          end else begin
            e = sb.pop_front();
            chk({e.nm, " HI"}, mdif.HI, e.hi);
            chk({e.nm, " LO"}, mdif.LO, e.lo);
            chk({e.nm, " busy_cycles"}, bcnt, e.cyc);
          end
          bcnt = 0;
        end
        busy_prev = mdif.Busy;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    mdif.IR_E = '0; mdif.RS_E = '0; mdif.RT_E = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst Busy", {31'd0, mdif.Busy}, 32'd0);
    chk("rst HI", mdif.HI, 32'd0);
    chk("rst LO", mdif.LO, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset clears state without a clock edge
    issue(MTHI, 32'hAAAA_5555, 32'd0, 1'b0, "mthi");
    issue(MTLO, 32'h5555_AAAA, 32'd0, 1'b0, "mtlo");
    chk("mthi HI", mdif.HI, 32'hAAAA_5555);
    chk("mtlo LO", mdif.LO, 32'h5555_AAAA);
    #2 rst = 1'b1;
    #1;
    chk("async HI", mdif.HI, 32'd0);
    chk("async LO", mdif.LO, 32'd0);
    @(negedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;

    expect_op(32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, "mult");
    issue(MULT, 32'hFFFF_FFFE, 32'd3, 1'b1, "mult");
    wait_done("mult");
    expect_op(32'h0000_0002, 32'hFFFF_FFFA, 5, "multu");
    issue(MULTU, 32'hFFFF_FFFE, 32'd3, 1'b1, "multu");
    wait_done("multu");
    expect_op(32'hFFFF_FFFE, 32'h0000_0001, 5, "multu_max");
    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "multu_max");
    wait_done("multu_max");
    expect_op(32'h0000_0000, 32'h0000_0001, 5, "mult_m1");
    issue(MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "mult_m1");
    wait_done("mult_m1");

    expect_op(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, "div");
    issue(DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, "div");
    wait_done("div");
    expect_op(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, "divu_by0");
    issue(DIVU, 32'd7, 32'd0, 1'b1, "divu_by0");
    wait_done("divu_by0");
    expect_op(32'h0000_0000, 32'h8000_0000, 10, "div_ovf");
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div_ovf");
    wait_done("div_ovf");
    expect_op(32'h0000_0001, 32'hFFFF_FFFD, 10, "div_negdiv");
    issue(DIV, 32'd7, 32'hFFFF_FFFE, 1'b1, "div_negdiv");
    wait_done("div_negdiv");
    expect_op(32'h0000_0001, 32'h7FFF_FFFF, 10, "divu");
    issue(DIVU, 32'hFFFF_FFFF, 32'd2, 1'b1, "divu");
    wait_done("divu");

    // mtlo/mflo, mthi/mfhi, then md instructions while busy
    issue(MTLO, 32'h1234_5678, 32'd0, 1'b0, "mtlo2");
    mdif.IR_E = MFLO; #1;
    chk("mflo MD_Out", mdif.MD_Out, 32'h1234_5678);
    @(posedge clk); #1;
    issue(MTHI, 32'h0BAD_F00D, 32'd0, 1'b0, "mthi2");
    mdif.IR_E = MFHI; #1;
    chk("mfhi MD_Out", mdif.MD_Out, 32'h0BAD_F00D);
    @(posedge clk); #1;
    mdif.IR_E = 32'd0; #1;
    chk("bubble MD_Out", mdif.MD_Out, 32'd0);
    @(posedge clk); #1;
    expect_op(32'd0, 32'd6, 5, "mult_busy");
    issue(MULT, 32'd2, 32'd3, 1'b1, "mult_busy");
    issue(MULT, 32'd4, 32'd5, 1'b0, "mult_while_busy");
    mdif.IR_E = MFHI; #1;
    chk("mfhi busy MD_Out", mdif.MD_Out, 32'h0BAD_F00D);
    @(posedge clk); #1;
    issue(MTLO, 32'hDEAD_BEEF, 32'd0, 1'b0, "mtlo_while_busy");
    wait_done("mult_busy");

    // Reset during a divide aborts it
    issue(DIV, 32'd100, 32'd7, 1'b1, "div_abort");
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort Busy", {31'd0, mdif.Busy}, 32'd0);
    chk("abort HI", mdif.HI, 32'd0);
    chk("abort LO", mdif.LO, 32'd0);
    @(negedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    expect_op(32'd0, 32'd42, 5, "mult_after_rst");
    issue(MULT, 32'd7, 32'd6, 1'b1, "mult_after_rst");
    wait_done("mult_after_rst");

    issue(MTHI, 32'd0, 32'd0, 1'b0, "mthi3");
    issue(MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0, "mtlo3");
`ifdef MD_MADD_EN
    expect_op(32'd1, 32'd0, 5, "maddu");
    issue(MADDU, 32'd1, 32'd1, 1'b1, "maddu");
    wait_done("maddu");
    expect_op(32'd0, 32'hFFFF_FFFF, 5, "madd");
    issue(MADD, 32'hFFFF_FFFF, 32'd1, 1'b1, "madd");
    wait_done("madd");
    issue(MTHI, 32'hFFFF_FFFF, 32'd0, 1'b0, "mthi4");
    expect_op(32'd0, 32'd0, 5, "maddu_wrap");
    issue(MADDU, 32'd1, 32'd1, 1'b1, "maddu_wrap");
    wait_done("maddu_wrap");
`else
    issue(MADDU, 32'd1, 32'd1, 1'b0, "maddu_off");
    issue(MADD, 32'd1, 32'd1, 1'b0, "madd_off");
    repeat (6) @(posedge clk);
    #1;
    chk("madd_off Busy", {31'd0, mdif.Busy}, 32'd0);
    chk("madd_off HI", mdif.HI, 32'd0);
    chk("madd_off LO", mdif.LO, 32'hFFFF_FFFF);
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
